// File: rtl/code842n1_pkg.sv
// Shared definitions for the 8,4,-2,-1 code packer.
//   - Legal code word constants and the filler digit used for illegal codes.
//   - FSM state encoding for the packer.
//   - is_legal_842n1(): true for the ten legal code words.
package code842n1_pkg;

  localparam logic [3:0] CODE_0 = 4'b0000;
  localparam logic [3:0] CODE_1 = 4'b0111;
  localparam logic [3:0] CODE_2 = 4'b0110;
  localparam logic [3:0] CODE_3 = 4'b0101;
  localparam logic [3:0] CODE_4 = 4'b0100;
  localparam logic [3:0] CODE_5 = 4'b1011;
  localparam logic [3:0] CODE_6 = 4'b1010;
  localparam logic [3:0] CODE_7 = 4'b1001;
  localparam logic [3:0] CODE_8 = 4'b1000;
  localparam logic [3:0] CODE_9 = 4'b1111;

  localparam logic [3:0] ILLEGAL_DIGIT = 4'hF;

  typedef enum logic {
    StFill = 1'b0,
    StHold = 1'b1
  } state_e;

  function automatic logic is_legal_842n1(input logic [3:0] code);
    logic legal;
    legal = 1'b0;
    case (code)
      CODE_0, CODE_1, CODE_2, CODE_3, CODE_4,
      CODE_5, CODE_6, CODE_7, CODE_8, CODE_9: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/code842n1_decode.sv
// Combinational 8,4,-2,-1 -> BCD digit decoder.
//   code_i    : 4-bit 8,4,-2,-1 code word
//   digit_o   : decoded BCD digit, ILLEGAL_DIGIT for unused code words
//   illegal_o : high when code_i is not one of the ten legal words
module code842n1_decode
  import code842n1_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] digit_o,
  output logic       illegal_o
);

  always_comb begin
    digit_o = ILLEGAL_DIGIT;
    case (code_i)
      CODE_0:  digit_o = 4'd0;
      CODE_1:  digit_o = 4'd1;
      CODE_2:  digit_o = 4'd2;
      CODE_3:  digit_o = 4'd3;
      CODE_4:  digit_o = 4'd4;
      CODE_5:  digit_o = 4'd5;
      CODE_6:  digit_o = 4'd6;
      CODE_7:  digit_o = 4'd7;
      CODE_8:  digit_o = 4'd8;
      CODE_9:  digit_o = 4'd9;
      default: digit_o = ILLEGAL_DIGIT;
    endcase
    illegal_o = ~is_legal_842n1(code_i);
  end

endmodule

// File: rtl/code842n1_digit_packer.sv
// Packs a stream of 8,4,-2,-1 coded digits into multi-digit BCD words.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_code is the coded digit
//   flush               : drop the partially assembled word (ignored while a word is held)
//   out_valid/out_ready : output handshake for out_bcd/out_err
//   out_bcd             : packed BCD, first received digit in the MS nibble
//   out_err             : at least one illegal code inside the current word
//   err_cnt             : saturating count of all illegal codes accepted
module code842n1_digit_packer
  import code842n1_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_code,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_err,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int unsigned CntW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned WordW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WordW-1:0]  asm_q, asm_d;
  logic              werr_q, werr_d;
  logic [WordW-1:0]  out_bcd_q, out_bcd_d;
  logic              out_err_q, out_err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [3:0]        dec_digit;
  logic              dec_illegal;
  logic              in_xfer;
  logic              last_digit;
  logic [WordW-1:0]  asm_shift;
  logic [WordW-1:0]  first_word;

  code842n1_decode u_decode (
    .code_i    (in_code),
    .digit_o   (dec_digit),
    .illegal_o (dec_illegal)
  );

  // Ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state_q == StFill) | out_ready;
  assign out_valid = (state_q == StHold);
  assign out_bcd   = out_bcd_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

  assign in_xfer    = in_valid & in_ready;
  assign last_digit = (cnt_q == CntW'(DIGITS - 1));

  always_comb begin
    asm_shift       = asm_q << 4;
    asm_shift[3:0]  = dec_digit;
    first_word      = '0;
    first_word[3:0] = dec_digit;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    werr_d    = werr_q;
    out_bcd_d = out_bcd_q;
    out_err_d = out_err_q;
    err_cnt_d = err_cnt_q;

    // Counted even when the digit itself is discarded by flush.
    if (in_xfer && dec_illegal && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end

    case (state_q)
      StFill: begin
        if (flush) begin
          cnt_d  = '0;
          asm_d  = '0;
          werr_d = 1'b0;
        end else if (in_xfer) begin
          if (last_digit) begin
            out_bcd_d = asm_shift;
            out_err_d = werr_q | dec_illegal;
            cnt_d     = '0;
            asm_d     = '0;
            werr_d    = 1'b0;
            state_d   = StHold;
          end else begin
            asm_d  = asm_shift;
            werr_d = werr_q | dec_illegal;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          if (in_valid) begin
            // Word leaves and the next word's first digit is taken on the same edge.
            if (DIGITS == 1) begin
              out_bcd_d = first_word;
              out_err_d = dec_illegal;
            end else begin
              asm_d   = first_word;
              werr_d  = dec_illegal;
              cnt_d   = CntW'(1);
              state_d = StFill;
            end
          end else begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      cnt_q     <= '0;
      asm_q     <= '0;
      werr_q    <= 1'b0;
      out_bcd_q <= '0;
      out_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      werr_q    <= werr_d;
      out_bcd_q <= out_bcd_d;
      out_err_q <= out_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
